// File: rtl/ofm_writeback_packer.sv
// OFM write-back packer: gathers 32-bit layer-2 result words into 128-bit
// lines and writes each line to global BRAM at consecutive 16-byte addresses.
module ofm_writeback_packer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  base_addr_OFM,
    input  logic [31:0]  size_OFM,
    input  logic         valid_layer2,
    input  logic [31:0]  data_layer2,
    output logic         ready_layer2,
    input  logic         flush,
    output logic [31:0]  wr_addr_global,
    output logic [127:0] wr_data_global,
    output logic         we_global,
    input  logic         global_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] byte_cnt;
    logic [31:0] byte_cnt_inc;
    logic [31:0] size_reg;
    logic [1:0]  lane_cnt;

    logic        xfer;
    logic        accept_start;
    logic        line_close;
    logic        write_done;

    // Byte count after the line currently in WRITE completes (wraps mod 2^32).
    assign byte_cnt_inc = byte_cnt + 32'd16;

    // A word is consumed only when the packer advertises ready (PACK only).
    assign xfer = valid_layer2 & ready_layer2;

    // State register; asynchronous reset returns to IDLE at once, which also
    // drops we_global combinationally in the middle of a WRITE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore-style control outputs.
    always_comb begin
        state_next   = state;
        ready_layer2 = 1'b0;
        we_global    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        accept_start = 1'b0;
        line_close   = 1'b0;
        write_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = (size_OFM == 32'd0) ? DONE : PACK;
                end
            end
            PACK: begin
                ready_layer2 = 1'b1;
                // A word landing in lane 3, or a flush that arrives with a
                // word, closes the line after storing that word. A bare flush
                // only closes a line that already holds at least one word.
                if (valid_layer2) begin
                    line_close = (lane_cnt == 2'd3) || flush;
                end else begin
                    line_close = flush && (lane_cnt != 2'd0);
                end
                if (line_close) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                we_global = 1'b1;
                if (global_ready) begin
                    write_done = 1'b1;
                    state_next = (byte_cnt_inc >= size_reg) ? DONE : PACK;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line register, lane/byte counters, line address and latched pass size.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_global <= 32'd0;
            wr_data_global <= 128'd0;
            byte_cnt       <= 32'd0;
            size_reg       <= 32'd0;
            lane_cnt       <= 2'd0;
        end else if (accept_start) begin
            wr_addr_global <= base_addr_OFM;
            wr_data_global <= 128'd0;
            byte_cnt       <= 32'd0;
            size_reg       <= size_OFM;
            lane_cnt       <= 2'd0;
        end else if (xfer) begin
            for (int n = 0; n < 4; n++) begin
                if (lane_cnt == 2'(n)) begin
                    wr_data_global[n*32 +: 32] <= data_layer2;
                end
            end
            lane_cnt <= line_close ? 2'd0 : lane_cnt + 2'd1;
        end else if (line_close) begin
            // Flush of a partial line: unfilled lanes already hold zero.
            lane_cnt <= 2'd0;
        end else if (write_done) begin
            wr_addr_global <= wr_addr_global + 32'd16;
            byte_cnt       <= byte_cnt_inc;
            wr_data_global <= 128'd0;
        end
    end

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Scoreboard bench for ofm_writeback_packer: stimulus pushes expected line
// writes into a queue, a negedge monitor pops and compares each BRAM write.
`timescale 1ns/1ps
module tb_ofm_writeback_packer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  base_addr_OFM;
    logic [31:0]  size_OFM;
    logic         valid_layer2;
    logic [31:0]  data_layer2;
    logic         ready_layer2;
    logic         flush;
    logic [31:0]  wr_addr_global;
    logic [127:0] wr_data_global;
    logic         we_global;
    logic         global_ready;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    ofm_writeback_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr_OFM  (base_addr_OFM),
        .size_OFM       (size_OFM),
        .valid_layer2   (valid_layer2),
        .data_layer2    (data_layer2),
        .ready_layer2   (ready_layer2),
        .flush          (flush),
        .wr_addr_global (wr_addr_global),
        .wr_data_global (wr_data_global),
        .we_global      (we_global),
        .global_ready   (global_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_line(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        wr_t e;
        e.addr = a;
        e.data = {w3, w2, w1, w0};
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s);
        base_addr_OFM = b;
        size_OFM      = s;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    // Present a word, wait (bounded) for ready, and let the transfer edge pass.
    // valid is left high so consecutive calls are back-to-back.
    task automatic push_word(input logic [31:0] w, input logic fl);
        int k;
        valid_layer2 = 1'b1;
        data_layer2  = w;
        flush        = fl;
        k = 0;
        while (!ready_layer2 && k < 20) begin
            tick();
            k++;
        end
        if (!ready_layer2) check("ready_timeout", 128'd0, 128'd1);
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
        end
        check("done_seen", {127'd0, done}, 128'd1);
        tick();
        check("done_one_cycle", {127'd0, done}, 128'd0);
        check("idle_after_done", {127'd0, busy}, 128'd0);
    endtask

    // Monitor: every completed BRAM write is compared against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && we_global && global_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {96'd0, wr_addr_global}, 128'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {96'd0, wr_addr_global}, {96'd0, e.addr});
                check("wr_data", wr_data_global, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n       = 1'b0;
        start         = 1'b0;
        base_addr_OFM = 32'd0;
        size_OFM      = 32'd0;
        valid_layer2  = 1'b0;
        data_layer2   = 32'd0;
        flush         = 1'b0;
        global_ready  = 1'b1;
        #2;
        check("rst_busy",  {127'd0, busy}, 128'd0);
        check("rst_done",  {127'd0, done}, 128'd0);
        check("rst_we",    {127'd0, we_global}, 128'd0);
        check("rst_ready", {127'd0, ready_layer2}, 128'd0);
        check("rst_addr",  {96'd0, wr_addr_global}, 128'd0);
        check("rst_data",  wr_data_global, 128'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Two full lines back-to-back, global_ready tied high.
        expect_line(32'h1000, 32'h01, 32'h02, 32'h03, 32'h04);
        expect_line(32'h1010, 32'h05, 32'h06, 32'h07, 32'h08);
        do_start(32'h1000, 32'd32);
        check("t1_busy", {127'd0, busy}, 128'd1);
        for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b0);
        check("t1_we_latency", {127'd0, we_global}, 128'd1);
        check("t1_ready_in_write", {127'd0, ready_layer2}, 128'd0);
        for (int i = 5; i <= 8; i++) push_word(32'(i), 1'b0);
        valid_layer2 = 1'b0;
        wait_done(cyc);
        check("t1_done_latency", cyc, 1);
        check("t1_final_addr", {96'd0, wr_addr_global}, 128'h1020);

        // Back-pressure: global_ready low for three WRITE cycles.
        global_ready = 1'b0;
        expect_line(32'h3000, 32'h11, 32'h22, 32'h33, 32'h44);
        do_start(32'h3000, 32'd16);
        push_word(32'h11, 1'b0);
        push_word(32'h22, 1'b0);
        push_word(32'h33, 1'b0);
        push_word(32'h44, 1'b0);
        valid_layer2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_we_hold",   {127'd0, we_global}, 128'd1);
            check("t2_addr_hold", {96'd0, wr_addr_global}, 128'h3000);
            check("t2_data_hold", wr_data_global, 128'h00000044_00000033_00000022_00000011);
            check("t2_ready_low", {127'd0, ready_layer2}, 128'd0);
            tick();
        end
        global_ready = 1'b1;
        wait_done(cyc);

        // Partial line via flush, ignored flush at lane 0, flush with word.
        expect_line(32'h4000, 32'hAA, 32'hBB, 32'h0, 32'h0);
        expect_line(32'h4010, 32'hCC, 32'h0, 32'h0, 32'h0);
        do_start(32'h4000, 32'd32);
        push_word(32'hAA, 1'b0);
        push_word(32'hBB, 1'b0);
        valid_layer2 = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_we", {127'd0, we_global}, 128'd1);
        tick();
        check("t3_back_to_pack", {127'd0, ready_layer2}, 128'd1);
        check("t3_addr_next", {96'd0, wr_addr_global}, 128'h4010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_ignored", {127'd0, ready_layer2}, 128'd1);
        check("t3_no_we", {127'd0, we_global}, 128'd0);
        push_word(32'hCC, 1'b1);
        valid_layer2 = 1'b0;
        check("t3_flush_with_word", {127'd0, we_global}, 128'd1);
        wait_done(cyc);

        // Zero-size pass.
        do_start(32'h7000, 32'd0);
        check("t4_busy", {127'd0, busy}, 128'd1);
        check("t4_done", {127'd0, done}, 128'd1);
        check("t4_no_we", {127'd0, we_global}, 128'd0);
        tick();
        check("t4_idle", {127'd0, busy}, 128'd0);
        check("t4_done_low", {127'd0, done}, 128'd0);

        // Reset in the middle of WRITE.
        global_ready = 1'b0;
        do_start(32'h5000, 32'd16);
        for (int i = 0; i < 4; i++) push_word(32'h50 + 32'(i), 1'b0);
        valid_layer2 = 1'b0;
        check("t5_in_write", {127'd0, we_global}, 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_we_async", {127'd0, we_global}, 128'd0);
        check("t5_busy", {127'd0, busy}, 128'd0);
        check("t5_ready", {127'd0, ready_layer2}, 128'd0);
        check("t5_addr", {96'd0, wr_addr_global}, 128'd0);
        check("t5_data", wr_data_global, 128'd0);
        tick();
        reset_n = 1'b1;
        global_ready = 1'b1;
        tick();
        tick();
        check("t5_no_write_after", {127'd0, we_global}, 128'd0);
        expect_line(32'h2000, 32'h61, 32'h62, 32'h63, 32'h64);
        do_start(32'h2000, 32'd16);
        for (int i = 1; i <= 4; i++) push_word(32'h60 + 32'(i), 1'b0);
        valid_layer2 = 1'b0;
        wait_done(cyc);

        // Start and valid held while in WRITE must not disturb the pass.
        global_ready = 1'b0;
        expect_line(32'h6000, 32'h71, 32'h72, 32'h73, 32'h74);
        expect_line(32'h6010, 32'h81, 32'h82, 32'h83, 32'h84);
        do_start(32'h6000, 32'd32);
        for (int i = 1; i <= 4; i++) push_word(32'h70 + 32'(i), 1'b0);
        start         = 1'b1;
        base_addr_OFM = 32'h9990;
        size_OFM      = 32'd0;
        valid_layer2  = 1'b1;
        data_layer2   = 32'hDEAD;
        tick();
        tick();
        start = 1'b0;
        check("t6_still_write", {127'd0, we_global}, 128'd1);
        check("t6_addr_kept", {96'd0, wr_addr_global}, 128'h6000);
        check("t6_no_ready", {127'd0, ready_layer2}, 128'd0);
        valid_layer2 = 1'b0;
        global_ready = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) push_word(32'h80 + 32'(i), 1'b0);
        valid_layer2 = 1'b0;
        wait_done(cyc);

        // Address wrap past 2^32.
        expect_line(32'hFFFF_FFF0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        expect_line(32'h0000_0000, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        do_start(32'hFFFF_FFF0, 32'd32);
        for (int i = 1; i <= 4; i++) push_word(32'hA0 + 32'(i), 1'b0);
        for (int i = 1; i <= 4; i++) push_word(32'hB0 + 32'(i), 1'b0);
        valid_layer2 = 1'b0;
        wait_done(cyc);
        check("t7_wrapped_addr", {96'd0, wr_addr_global}, 128'h10);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ofm_writeback_packer.md
OFM_WRITEBACK_PACKER -- requirements
Module: ofm_writeback_packer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; begins one OFM write-back pass.
REQ-004 base_addr_OFM  input  32  byte address of the first OFM line in global BRAM; sampled on accepted start.
REQ-005 size_OFM  input  32  OFM size in bytes, multiple of 16; sampled on accepted start.
REQ-006 valid_layer2  input  1  a layer-2 result word is present on data_layer2.
REQ-007 data_layer2  input  32  layer-2 result word.
REQ-008 ready_layer2  output  1  packer accepts a word this cycle; transfer = valid_layer2 & ready_layer2.
REQ-009 flush  input  1  one-cycle pulse; forces write of a partially filled line.
REQ-010 wr_addr_global  output  32  byte address of the line being written.
REQ-011 wr_data_global  output  128  packed line.
REQ-012 we_global  output  1  write request to global BRAM.
REQ-013 global_ready  input  1  BRAM side accepts the write; write completes when we_global & global_ready.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at pass completion.

Function
REQ-016 States SHALL be IDLE, PACK, WRITE, DONE.
REQ-017 IDLE -> PACK on start when size_OFM != 0; IDLE -> DONE on start when size_OFM == 0; start SHALL be ignored outside IDLE.
REQ-018 On accepted start: wr_addr_global <= base_addr_OFM, byte counter <= 0, lane counter <= 0, line register <= 0.
REQ-019 ready_layer2 SHALL be 1 only in PACK (combinational from state), 0 otherwise.
REQ-020 In PACK, each transfer SHALL write data_layer2 into lane n of the line register, bits [32n+31:32n], n = lane counter 0..3, first word in lane 0, then increment lane counter.
REQ-021 The transfer filling lane 3 SHALL move PACK -> WRITE on the next edge, with lane counter reset to 0.
REQ-022 flush in PACK with lane counter > 0 and no same-cycle transfer SHALL move PACK -> WRITE; unfilled lanes SHALL hold 0; flush with lane counter == 0 SHALL be ignored.
REQ-023 flush coinciding with a transfer SHALL store that word first, then move to WRITE.
REQ-024 In WRITE, we_global SHALL be 1 and wr_data_global/wr_addr_global SHALL hold stable until global_ready is sampled 1.
REQ-025 On write completion: wr_addr_global += 16, byte counter += 16, line register <= 0, we_global <= 0; if new byte counter >= size_OFM go DONE, else go PACK.
REQ-026 Minimum latency: last word of a line accepted in cycle t -> we_global high in t+1; with global_ready tied 1 a line costs 5 cycles (4 PACK + 1 WRITE).
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE; wr_addr_global holds its final value.
REQ-028 Address and byte-counter arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32 without error.
REQ-029 valid_layer2 outside PACK SHALL not change state; data is not consumed (ready_layer2 = 0).

Reset
REQ-030 While reset_n = 0: state IDLE, we_global 0, done 0, busy 0, ready_layer2 0, wr_addr_global 0, wr_data_global 0, all counters 0.
REQ-031 Reset asserted mid-WRITE SHALL immediately drop we_global and discard the partial pass; no line is written after reset release until a new start.

Verification
REQ-032 base 0x1000, size 32, global_ready=1, 8 words 0x01..0x08 back-to-back -> writes {0x04,0x03,0x02,0x01} @0x1000 and {0x08..0x05} @0x1010, done pulse one cycle after second write.
REQ-033 size 16, global_ready held 0 for 3 cycles in WRITE -> we_global, addr, data stable 3 cycles, ready_layer2 = 0 throughout, single write on 4th cycle.
REQ-034 size 32, 2 words 0xAA,0xBB then flush -> write {0,0,0xBB,0xAA} @base, FSM returns to PACK (16 < 32).
REQ-035 start with size 0 -> busy 1 cycle, done pulse, no we_global.
REQ-036 reset_n low during WRITE -> we_global 0 asynchronously, all outputs at reset values; subsequent start with base 0x2000 writes first line at 0x2000.
REQ-037 start pulse while busy plus valid_layer2 held in WRITE -> no restart, no extra transfers, addresses unchanged.
